// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and default burst limit for bram_arbiter
package bram_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
   localparam int DEFAULT_MAX_BURST = 16;
endpackage

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester burst arbiter driving one single-port BRAM.
// Define BRAM_ARB_RR_EN for round-robin selection from IDLE when both ports request.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int RAM_WIDTH = 16,
   parameter int RAM_ADDR_BITS = 17,
   parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req0,
   input  logic                     req1,
   input  logic                     we0,
   input  logic                     we1,
   input  logic [RAM_ADDR_BITS-1:0] addr0,
   input  logic [RAM_ADDR_BITS-1:0] addr1,
   input  logic [RAM_WIDTH-1:0]     wdata0,
   input  logic [RAM_WIDTH-1:0]     wdata1,
   output logic                     gnt0,
   output logic                     gnt1,
   output logic [RAM_WIDTH-1:0]     rdata0,
   output logic [RAM_WIDTH-1:0]     rdata1,
   output logic                     rvalid0,
   output logic                     rvalid1,
   output logic                     ram_enable,
   output logic                     write_enable,
   output logic [RAM_ADDR_BITS-1:0] address,
   output logic [RAM_WIDTH-1:0]     input_data,
   input  logic [RAM_WIDTH-1:0]     output_data
);
   localparam int CW = $clog2(MAX_BURST + 1);
   state_t state, state_nx;
   logic [CW-1:0] beats;
   logic own0, own1, req_own, req_oth, acc, rel, pick1;
   logic rd_v, rd_tag;
   logic [RAM_WIDTH-1:0] rd0_q, rd1_q;
   assign own0 = state == OWN0;
   assign own1 = state == OWN1;
   assign gnt0 = own0 & req0;
   assign gnt1 = own1 & req1;
   assign acc = gnt0 | gnt1;
   assign req_own = own1 ? req1 : req0;
   assign req_oth = own1 ? req0 : req1;
   assign rel = (own0 | own1) & (!req_own | (acc & (beats == CW'(MAX_BURST - 1))));
   assign ram_enable = acc;
   assign write_enable = (gnt0 & we0) | (gnt1 & we1);
   assign address = own1 ? addr1 : own0 ? addr0 : '0;
   assign input_data = own1 ? wdata1 : own0 ? wdata0 : '0;
`ifdef BRAM_ARB_RR_EN
   logic last_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) last_q <= 1'b1;
      else if (own0 | own1) last_q <= own1;
   assign pick1 = req1 & (!req0 | !last_q);
`else
   assign pick1 = req1 & !req0;
`endif
   // an unreachable encoding falls back to IDLE behaviour
   always_comb begin
      state_nx = state;
      if (!(own0 | own1))
         state_nx = (req0 | req1) ? (pick1 ? OWN1 : OWN0) : IDLE;
      else if (rel)
         state_nx = req_oth ? (own1 ? OWN0 : OWN1) : req_own ? state : IDLE;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state  <= IDLE;
         beats  <= '0;
         rd_v   <= 1'b0;
         rd_tag <= 1'b0;
         rd0_q  <= '0;
         rd1_q  <= '0;
      end else begin
         state  <= state_nx;
         beats  <= (rel || state_nx != state) ? '0 : beats + CW'(acc);
         rd_v   <= acc & !write_enable;
         rd_tag <= gnt1;
         if (rvalid0) rd0_q <= output_data;
         if (rvalid1) rd1_q <= output_data;
      end
   // read data is live from the BRAM on the return cycle, then held
   assign rvalid0 = rd_v & !rd_tag;
   assign rvalid1 = rd_v & rd_tag;
   assign rdata0 = rvalid0 ? output_data : rd0_q;
   assign rdata1 = rvalid1 ? output_data : rd1_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: vector table, reset corner sequence and randomized run against a BRAM/arbiter model
`timescale 1ns/1ps
module tb_bram_arbiter;
   localparam int W = 16;
   localparam int AB = 17;
   localparam int MB = 4;
`ifdef BRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [AB-1:0] addr0 = '0, addr1 = '0;
   logic [W-1:0] wdata0 = '0, wdata1 = '0;
   logic gnt0, gnt1, rvalid0, rvalid1, ram_enable, write_enable;
   logic [W-1:0] rdata0, rdata1, input_data, output_data;
   logic [AB-1:0] address;
   logic [W-1:0] mem [0:1023];
   logic [W-1:0] sh [0:1023];
   logic pre_en = 1'b0;
   logic [9:0] pre_a = '0;
   logic [W-1:0] pre_d = '0;
   int tests = 0;
   int fails = 0;

   bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB), .MAX_BURST(MB)) dut (
      .clock(clock), .reset_n(reset_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .ram_enable(ram_enable), .write_enable(write_enable),
      .address(address), .input_data(input_data), .output_data(output_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (ram_enable) begin
         if (write_enable) mem[address[9:0]] <= input_data;
         else output_data <= mem[address[9:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic r0, w0; logic [AB-1:0] a0; logic [W-1:0] d0;
      logic r1, w1; logic [AB-1:0] a1; logic [W-1:0] d1;
      logic g0, g1, v0, v1; logic [W-1:0] q0, q1;
   } vec_t;
   vec_t vt[$];

   task automatic add(input logic r0, w0, input logic [AB-1:0] a0, input logic [W-1:0] d0,
                      input logic r1, w1, input logic [AB-1:0] a1, input logic [W-1:0] d1,
                      input logic g0, g1, v0, v1, input logic [W-1:0] q0, q1);
      vt.push_back('{r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, v0, v1, q0, q1});
   endtask

   initial begin
      logic first, on, p, g0, g1, pg0, pg1, pv, acc;
      logic [W-1:0] e0, e1, pd;
      logic rq [2], wq [2], eg [2];
      logic [AB-1:0] aq [2];
      logic [W-1:0] dq [2], er [2];
      int own, beats, last, pp, o;
      first = RR;
      // single-owner reads, then a port-1 write read back by port 0
      add(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
      add(1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0);
      add(1, 0, 'h11, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'hA000, 0);
      add(1, 0, 'h12, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'hA001, 0);
      add(1, 0, 'h13, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'hA002, 0);
      add(0, 0, 'h13, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hA003, 0);
      add(0, 0, 'h13, 0, 1, 1, 'h100, 16'h5A5A, 0, 0, 0, 0, 16'hA003, 0);
      add(0, 0, 'h13, 0, 1, 1, 'h100, 16'h5A5A, 0, 1, 0, 0, 16'hA003, 0);
      add(1, 0, 'h100, 0, 0, 0, 'h100, 0, 0, 0, 0, 0, 16'hA003, 0);
      add(1, 0, 'h100, 0, 0, 0, 'h100, 0, 1, 0, 0, 0, 16'hA003, 0);
      add(0, 0, 'h100, 0, 0, 0, 'h100, 0, 0, 0, 1, 0, 16'h5A5A, 0);
      add(0, 0, 'h100, 0, 0, 0, 'h100, 0, 0, 0, 0, 0, 16'h5A5A, 0);
      // both requesting continuously: blocks of MB beats, first block depends on the build
      pg0 = 0; pg1 = 0; e0 = 16'h5A5A; e1 = 16'h0000;
      for (int i = 0; i <= 14; i++) begin
         on = i >= 1 && i <= 12;
         p = (((i + 3) / 4) % 2 == 1) ? first : !first;
         g0 = on && !p;
         g1 = on && p;
         if (pg0) e0 = 16'hA000;
         if (pg1) e1 = 16'hA001;
         add(i <= 12, 0, 'h10, 0, i <= 12, 0, 'h11, 0, g0, g1, pg0, pg1, e0, e1);
         pg0 = g0;
         pg1 = g1;
      end
      pre_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pre_a = 10'h10 + 10'(i);
         pre_d = 16'hA000 + 16'(i);
         @(posedge clock); #1;
      end
      pre_en = 1'b0;
      @(negedge clock);
      chk("rst gnt0", gnt0, 0);
      chk("rst gnt1", gnt1, 0);
      chk("rst rvalid0", rvalid0, 0);
      chk("rst rvalid1", rvalid1, 0);
      chk("rst rdata0", rdata0, 0);
      chk("rst rdata1", rdata1, 0);
      chk("rst ram_enable", ram_enable, 0);
      chk("rst write_enable", write_enable, 0);
      chk("rst address", address, 0);
      chk("rst input_data", input_data, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < vt.size(); i++) begin
         req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
         req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
         @(negedge clock);
         chk($sformatf("vec%0d gnt0", i), gnt0, vt[i].g0);
         chk($sformatf("vec%0d gnt1", i), gnt1, vt[i].g1);
         chk($sformatf("vec%0d rvalid0", i), rvalid0, vt[i].v0);
         chk($sformatf("vec%0d rvalid1", i), rvalid1, vt[i].v1);
         chk($sformatf("vec%0d rdata0", i), rdata0, vt[i].q0);
         chk($sformatf("vec%0d rdata1", i), rdata1, vt[i].q1);
         @(posedge clock); #1;
      end
      // reset one cycle after an accepted read, then a lone port-1 request
      req0 = 1'b1; we0 = 1'b0; addr0 = 'h12; req1 = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      chk("pre-rst gnt0", gnt0, 1);
      @(posedge clock); #1;
      reset_n = 1'b0;
      req0 = 1'b0;
      @(negedge clock);
      chk("mid-rst rvalid0", rvalid0, 0);
      chk("mid-rst rvalid1", rvalid1, 0);
      chk("mid-rst gnt0", gnt0, 0);
      chk("mid-rst ram_enable", ram_enable, 0);
      chk("mid-rst rdata0", rdata0, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 'h13;
      @(negedge clock);
      chk("post-rst gnt1 c1", gnt1, 0);
      chk("post-rst rvalid0", rvalid0, 0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("post-rst gnt1 c2", gnt1, 1);
      @(posedge clock); #1;
      req1 = 1'b0;
      @(negedge clock);
      chk("post-rst rvalid1", rvalid1, 1);
      chk("post-rst rdata1", rdata1, 16'hA003);
      // randomized traffic against a behavioural model
      @(posedge clock); #1;
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 1024; i++) sh[i] = mem[i];
      own = -1; beats = 0; last = 1; pv = 0; pp = 0; pd = '0;
      er[0] = '0; er[1] = '0;
      rq[0] = 0; rq[1] = 0; wq[0] = 0; wq[1] = 0;
      aq[0] = '0; aq[1] = '0; dq[0] = '0; dq[1] = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         o = own < 0 ? 0 : own;
         acc = own >= 0 && rq[o];
         eg[0] = own == 0 && rq[0];
         eg[1] = own == 1 && rq[1];
         chk("rnd gnt0", gnt0, eg[0]);
         chk("rnd gnt1", gnt1, eg[1]);
         chk("rnd rvalid0", rvalid0, pv && pp == 0);
         chk("rnd rvalid1", rvalid1, pv && pp == 1);
         if (pv) er[pp] = pd;
         chk("rnd rdata0", rdata0, er[0]);
         chk("rnd rdata1", rdata1, er[1]);
         chk("rnd ram_enable", ram_enable, acc);
         if (acc) begin
            chk("rnd address", address, aq[o]);
            chk("rnd write_enable", write_enable, wq[o]);
            if (wq[o]) chk("rnd input_data", input_data, dq[o]);
         end
         pv = acc && !wq[o];
         if (acc) begin
            pp = o;
            pd = sh[aq[o][9:0]];
            if (wq[o]) sh[aq[o][9:0]] = dq[o];
         end
         if (own < 0) begin
            if (rq[0] || rq[1]) own = (rq[0] && rq[1]) ? (RR ? 1 - last : 0) : (rq[0] ? 0 : 1);
         end else begin
            last = own;
            beats += acc ? 1 : 0;
            if (!rq[own] || beats == MB) begin
               own = rq[1 - own] ? 1 - own : rq[own] ? own : -1;
               beats = 0;
            end
         end
         @(posedge clock); #1;
         for (int k = 0; k < 2; k++) begin
            if (!rq[k] || eg[k]) begin
               rq[k] = $urandom_range(3) != 0;
               wq[k] = $urandom_range(2) == 0;
               aq[k] = AB'($urandom_range(31));
               dq[k] = W'($urandom);
            end else if ($urandom_range(7) == 0) rq[k] = 1'b0;
         end
         req0 = rq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
         req1 = rq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
